// File: rtl/uart_rx_16bit.sv
// uart_rx_16bit: 8N1 UART receiver that pairs consecutive bytes into 16-bit words, low byte first.
// Optional define UART_RX_TIMEOUT_EN: a lone low byte is dropped after TIMEOUT_BITS idle bit periods.
module uart_rx_16bit #(
   parameter int CLK_FREQ     = 50000000,
   parameter int UART_BPS     = 115200,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        uart_rxd,
   output logic        word_valid,
   output logic [15:0] word_data,
   output logic        frame_err,
   output logic        rx_busy
);
   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CW      = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
   localparam logic [CW-1:0] BIT_END  = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(BPS_CNT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, next_state;

   logic          rxd_s1, rxd_s2, rxd_s3;
   logic          rxd_fall;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic [7:0]    low_byte;
   logic          hi_next;
   logic          byte_done;
   logic          stop_bit;
   logic          half_hit;
   logic          bit_hit;
   logic          timeout_hit;

   // Synchronise the async line; the third stage gives a falling-edge detect
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
         rxd_s3 <= 1'b1;
      end else begin
         rxd_s1 <= uart_rxd;
         rxd_s2 <= rxd_s1;
         rxd_s3 <= rxd_s2;
      end
   end

   assign rxd_fall = rxd_s3 & ~rxd_s2;
   assign half_hit = (clk_cnt == HALF_END);
   assign bit_hit  = (clk_cnt == BIT_END);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (rxd_fall) next_state = START;
         START: if (half_hit) next_state = rxd_s2 ? IDLE : DATA;
         DATA:  if (bit_hit && bit_cnt == 3'd7) next_state = STOP;
         STOP:  if (bit_hit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      rx_busy = (state != IDLE);
   end

   // START counts to mid-start, so every later BPS_CNT wrap lands mid-bit
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clk_cnt   <= '0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         case (state)
            START: begin
               clk_cnt <= half_hit ? '0 : clk_cnt + 1'b1;
               bit_cnt <= 3'd0;
            end
            DATA: begin
               if (bit_hit) begin
                  clk_cnt            <= '0;
                  shift_reg[bit_cnt] <= rxd_s2;
                  bit_cnt            <= bit_cnt + 3'd1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: clk_cnt <= bit_hit ? '0 : clk_cnt + 1'b1;
            default: begin
               clk_cnt <= '0;
               bit_cnt <= 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         byte_done <= 1'b0;
         stop_bit  <= 1'b1;
      end else begin
         byte_done <= (state == STOP) && bit_hit;
         stop_bit  <= rxd_s2;
      end
   end

   // Pairing acts one edge after the stop sample; a bad stop realigns to a low byte
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         word_valid <= 1'b0;
         word_data  <= 16'd0;
         frame_err  <= 1'b0;
         low_byte   <= 8'd0;
         hi_next    <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (byte_done) begin
            if (!stop_bit) begin
               frame_err <= 1'b1;
               hi_next   <= 1'b0;
            end else if (hi_next) begin
               word_data  <= {shift_reg, low_byte};
               word_valid <= 1'b1;
               hi_next    <= 1'b0;
            end else begin
               low_byte <= shift_reg;
               hi_next  <= 1'b1;
            end
         end else if (timeout_hit) begin
            low_byte <= 8'd0;
            hi_next  <= 1'b0;
         end
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
   localparam int TW       = $clog2(TO_LIMIT + 1);
   localparam logic [TW-1:0] TO_END = TW'(TO_LIMIT - 1);

   logic [TW-1:0] idle_cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idle_cnt <= '0;
      end else if (state != IDLE || !hi_next || rxd_fall) begin
         idle_cnt <= '0;
      end else if (!timeout_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == IDLE) && hi_next && !rxd_fall && (idle_cnt == TO_END);
`else
   // Without the timeout a lone low byte waits forever; the term only keeps the parameter referenced
   assign timeout_hit = 1'b0 & (TIMEOUT_BITS < 0);
`endif

endmodule
